// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, BURST)
//   - cnt_width   : width of the FIFO occupancy count for a given depth
//   - beat_width  : width of the per-burst beat counter for a given cap
//   - rr_first    : rotating-priority pick over a request vector of up to
//                   RR_MAX_REQ bits; returns {found, index}
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // The pick helper works on a fixed-size vector; callers zero-extend.
  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // First set bit at or after ptr, wrapping modulo num_req. The scan runs from
  // the largest offset down so the smallest offset is the one left standing.
  function automatic logic [RR_IDX_W:0] rr_first(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [RR_IDX_W-1:0]   ptr,
    input int                    num_req
  );
    logic [RR_IDX_W:0] res;
    int                idx;
    res = '0;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < num_req) begin
        idx = (int'(ptr) + k) % num_req;
        if (req[idx]) res = {1'b1, RR_IDX_W'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
// Ports:
//   req_i   [NUM_REQ]  : request vector
//   ptr_i   [ID_WIDTH] : highest-priority index this cycle
//   idx_o   [ID_WIDTH] : winning index (valid when found_o)
//   found_o            : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                found_o
);

  logic [RR_MAX_REQ-1:0] req_ext;
  logic [RR_IDX_W-1:0]   ptr_ext;
  logic [RR_IDX_W:0]     pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    // ptr_i is always below NUM_REQ (<= 8), so narrowing keeps its value.
    ptr_ext                = RR_IDX_W'(ptr_i);
    pick                   = rr_first(req_ext, ptr_ext, NUM_REQ);
    found_o                = pick[RR_IDX_W];
    idx_o                  = ID_WIDTH'(pick[RR_IDX_W-1:0]);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the async FIFO's single write port among NUM_REQ
// requesters (write clock domain). Grants whole bursts ended by req_last or by
// a MAX_BURST beat cap, and tags every word with the source ID.
//
// Ports:
//   wr_clk, rst_n (async, active-low)
//   req_valid/req_last [NUM_REQ], req_data [NUM_REQ*DATA_WIDTH] (packed)
//   req_ready [NUM_REQ]            : accept, only to the granted requester
//   fifo_write, fifo_wdata         : {grant_id, payload}, zero when idle
//   fifo_full, fifo_wr_count       : FIFO write-side flags
//   busy                           : burst in progress
//   grant_id                       : current or last granted requester
//
// Build option: define FIFO_ARB_SPACE_CHECK_EN to start a burst only when the
// FIFO reports at least MIN_SPACE free entries (otherwise only !fifo_full).
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 4,
  parameter int MIN_SPACE  = 4
) (
  input  logic                             wr_clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             fifo_write,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]   fifo_wdata,
  input  logic                             fifo_full,
  input  logic [cnt_width(FIFO_DEPTH)-1:0] fifo_wr_count,
  output logic                             busy,
  output logic [ID_WIDTH-1:0]              grant_id
);

  localparam int CNT_W  = cnt_width(FIFO_DEPTH);
  localparam int BEAT_W = beat_width(MAX_BURST);

`ifdef FIFO_ARB_SPACE_CHECK_EN
  localparam bit SPACE_CHECK = 1'b1;
`else
  localparam bit SPACE_CHECK = 1'b0;
`endif

  arb_state_t            state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   grant_id_q;
  logic [BEAT_W-1:0]     beat_cnt_q;

  logic [CNT_W-1:0]      occ_clamped;
  logic [CNT_W-1:0]      free_space;
  logic                  space_ok;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  in_burst;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  burst_end;
  logic [ID_WIDTH-1:0]   next_ptr;

  // Admission: out-of-range occupancy is treated as completely full.
  always_comb begin
    occ_clamped = (fifo_wr_count > CNT_W'(FIFO_DEPTH)) ? CNT_W'(FIFO_DEPTH) : fifo_wr_count;
    free_space  = CNT_W'(FIFO_DEPTH) - occ_clamped;
    space_ok    = !fifo_full && (!SPACE_CHECK || (free_space >= CNT_W'(MIN_SPACE)));
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Granted-requester view and write datapath (combinational so a full FIFO
  // blocks the beat in the same cycle).
  assign in_burst = (state_q == BURST);
  assign g_valid  = req_valid[grant_id_q];
  assign g_last   = req_last[grant_id_q];
  assign g_data   = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) req_ready[grant_id_q] = 1'b1;
  end

  assign fifo_write = in_burst && !fifo_full && g_valid;
  assign fifo_wdata = fifo_write ? {grant_id_q, g_data} : '0;

  // Cap test uses the pre-increment count: this write is beat beat_cnt_q+1.
  assign burst_end = g_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
  assign next_ptr  = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign busy     = in_burst;
  assign grant_id = grant_id_q;

  // Arbitration FSM
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found && space_ok) begin
            grant_id_q <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (fifo_write) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (burst_end) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ID_WIDTH   = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int MIN_SPACE  = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int WW         = ID_WIDTH + DATA_WIDTH;

  logic                          wr_clk = 1'b0;
  logic                          rst_n  = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ-1:0]            req_last  = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_write;
  logic [WW-1:0]                 fifo_wdata;
  logic                          fifo_full = 1'b0;
  logic [CW-1:0]                 fifo_wr_count = '0;
  logic                          busy;
  logic [ID_WIDTH-1:0]           grant_id;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_BURST  (MAX_BURST),
    .MIN_SPACE  (MIN_SPACE)
  ) dut (
    .wr_clk        (wr_clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_write    (fifo_write),
    .fifo_wdata    (fifo_wdata),
    .fifo_full     (fifo_full),
    .fifo_wr_count (fifo_wr_count),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 wr_clk = ~wr_clk;

  // Observed outputs packed: {write[17], wdata[16:7], ready[6:3], busy[2], gid[1:0]}
  logic [17:0] obs;
  assign obs = {fifo_write, fifo_wdata, req_ready, busy, grant_id};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pk(input logic w, input logic [WW-1:0] wd,
                                     input logic [3:0] rdy, input logic b, input logic [1:0] g);
    return {w, wd, rdy, b, g};
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic [17:0] e;
  } vec_t;
  vec_t vt[13];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic f, input logic [17:0] e);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.f = f; t.e = e;
    return t;
  endfunction

  // ---------------- requester sources for hand sequences ----------------
  int rem[NUM_REQ];
  int seq[NUM_REQ];
  int reload[NUM_REQ];
  logic [WW-1:0] wlog[$];
  logic [17:0]   s_obs;

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_wr_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0; seq[i] = 0; reload[i] = 0;
    end
    wlog.delete();
    @(negedge wr_clk);
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  // One cycle: drive from sources, sample at negedge, advance on accept.
  task automatic step();
    logic [NUM_REQ-1:0] rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_last[i]  = (rem[i] == 1);
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'((i << 4) | (seq[i] & 15));
    end
    @(negedge wr_clk);
    rdy   = req_ready;
    s_obs = obs;
    if (fifo_write) wlog.push_back(fifo_wdata);
    @(posedge wr_clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && rdy[i]) begin
        rem[i]--;
        seq[i]++;
        if (rem[i] == 0) rem[i] = reload[i];
      end
    end
    #1;
  endtask

  task automatic chk_log(input string name, input logic [WW-1:0] exp[$]);
    chk({name, " count"}, wlog.size(), exp.size());
    for (int k = 0; k < exp.size() && k < wlog.size(); k++)
      chk($sformatf("%s word%0d", name, k), wlog[k], exp[k]);
  endtask

  // ---------------- reference model state (random test) ----------------
  int m_owner, m_beats, m_ptr, m_gid;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] exp_q[$];

    // Reset state while rst_n is held low.
    @(negedge wr_clk);
    chk("reset outputs", obs, 18'd0);

    // ---- table-driven single-requester / pointer / full-in-IDLE checks ----
    vt[0]  = mk(4'b0001, 4'b0000, 32'h11,   1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd0));
    vt[1]  = mk(4'b0001, 4'b0000, 32'h11,   1'b0, pk(1, 10'h011, 4'b0001, 1, 2'd0));
    vt[2]  = mk(4'b0001, 4'b0000, 32'h22,   1'b0, pk(1, 10'h022, 4'b0001, 1, 2'd0));
    vt[3]  = mk(4'b0001, 4'b0001, 32'h33,   1'b0, pk(1, 10'h033, 4'b0001, 1, 2'd0));
    vt[4]  = mk(4'b0000, 4'b0000, 32'h0,    1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd0));
    vt[5]  = mk(4'b0011, 4'b0011, 32'h4455, 1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd0));
    vt[6]  = mk(4'b0011, 4'b0011, 32'h4455, 1'b0, pk(1, 10'h144, 4'b0010, 1, 2'd1));
    vt[7]  = mk(4'b0000, 4'b0000, 32'h0,    1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd1));
    vt[8]  = mk(4'b0001, 4'b0001, 32'h77,   1'b1, pk(0, 10'h000, 4'b0000, 0, 2'd1));
    vt[9]  = mk(4'b0001, 4'b0001, 32'h77,   1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd1));
    vt[10] = mk(4'b0001, 4'b0001, 32'h77,   1'b1, pk(0, 10'h000, 4'b0000, 1, 2'd0));
    vt[11] = mk(4'b0001, 4'b0001, 32'h77,   1'b0, pk(1, 10'h077, 4'b0001, 1, 2'd0));
    vt[12] = mk(4'b0000, 4'b0000, 32'h0,    1'b0, pk(0, 10'h000, 4'b0000, 0, 2'd0));

    do_reset();
    for (int k = 0; k < 13; k++) begin
      req_valid = vt[k].v;
      req_last  = vt[k].l;
      req_data  = vt[k].d;
      fifo_full = vt[k].f;
      @(negedge wr_clk);
      chk($sformatf("vec%0d", k), obs, vt[k].e);
      @(posedge wr_clk);
      #1;
    end

    // ---- round robin: all requesters post 1-word bursts continuously ----
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin rem[i] = 1; reload[i] = 1; end
    repeat (10) step();
    exp_q = '{10'h000, 10'h110, 10'h220, 10'h330, 10'h001};
    chk_log("rr", exp_q);

    // ---- truncation: req2 sends 6 words, req1 pending ----
    do_reset();
    rem[2] = 6;
    step();
    rem[1] = 1;
    repeat (9) step();
    exp_q = '{10'h220, 10'h221, 10'h222, 10'h223, 10'h110, 10'h224, 10'h225};
    chk_log("trunc", exp_q);

    // ---- full stall after beat 2 of a 4-beat burst ----
    do_reset();
    rem[0] = 4;
    repeat (3) step();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall%0d", c), s_obs, pk(0, 10'h000, 4'b0000, 1, 2'd0));
    end
    fifo_full = 1'b0;
    repeat (2) step();
    step();
    chk("stall end idle", s_obs, 18'd0);
    exp_q = '{10'h000, 10'h001, 10'h002, 10'h003};
    chk_log("stall", exp_q);

    // ---- space check with fifo_wr_count = 13 ----
    do_reset();
    fifo_wr_count = CW'(13);
    rem[0] = 1;
    step();
    step();
`ifdef FIFO_ARB_SPACE_CHECK_EN
    chk("space13 busy", s_obs[2], 1'b0);
    fifo_wr_count = CW'(12);
    step();
    chk("space12 same cycle", s_obs[2], 1'b0);
    step();
    chk("space12 grant", s_obs, pk(1, 10'h000, 4'b0001, 1, 2'd0));
`else
    chk("space13 busy", s_obs, pk(1, 10'h000, 4'b0001, 1, 2'd0));
`endif
    fifo_wr_count = '0;

    // ---- reset mid-burst ----
    do_reset();
    rem[1] = 1;
    rem[2] = 4;
    repeat (4) step();
    @(negedge wr_clk);
    chk("beat2 write", {obs[17], obs[1:0]}, {1'b1, 2'd2});
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", obs, 18'd0);
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    req_valid = '0;
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
    rem[0] = 1;
    rem[3] = 1;
    step();
    chk("post reset idle", s_obs[2], 1'b0);
    step();
    chk("post reset ptr0", {s_obs[2], s_obs[1:0]}, {1'b1, 2'd0});

    // ---- randomized stimulus against the reference model ----
    do_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_gid = 0;
    for (int c = 0; c < 500; c++) begin
      logic        ew, ok;
      logic [3:0]  erdy;
      logic [WW-1:0] ewd;
      int          o;
      req_valid     = 4'($urandom);
      req_last      = 4'($urandom & $urandom);
      req_data      = $urandom;
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_wr_count = CW'($urandom_range(0, 24));
      @(negedge wr_clk);
      o    = (m_owner < 0) ? 0 : m_owner;
      ew   = (m_owner >= 0) && req_valid[o] && !fifo_full;
      erdy = (m_owner >= 0 && !fifo_full) ? 4'(1 << o) : 4'd0;
      ewd  = ew ? WW'(o * 256 + int'(req_data[o*DATA_WIDTH +: DATA_WIDTH])) : '0;
      chk($sformatf("random cycle %0d", c), obs, pk(ew, ewd, erdy, (m_owner >= 0), 2'(m_gid)));
      @(posedge wr_clk);
      if (m_owner < 0) begin
        ok = !fifo_full;
`ifdef FIFO_ARB_SPACE_CHECK_EN
        ok = ok && ((FIFO_DEPTH - ((int'(fifo_wr_count) > FIFO_DEPTH) ? FIFO_DEPTH
                                   : int'(fifo_wr_count))) >= MIN_SPACE);
`endif
        if (ok) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (m_owner < 0 && req_valid[(m_ptr + k) % NUM_REQ]) begin
              m_owner = (m_ptr + k) % NUM_REQ;
              m_gid   = m_owner;
              m_beats = 0;
            end
          end
        end
      end else if (ew) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MAX_BURST) begin
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
